// File: rtl/gold_miner_pkg.sv
// Shared types, loot-table shapes and arithmetic helpers for the multi-level claw/loot game controller.
package gold_miner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEVEL_START,
        ST_SWING,
        ST_GOING_DOWN,
        ST_HOLD,
        ST_GOING_BACK,
        ST_LEVEL_END,
        ST_GAME_DONE
    } state_t;

    // Loot tables hold up to 16 types; each entry is 32 bits and is narrowed by the user.
    localparam int TBL_IDX_W   = 4;
    localparam int DEF_SPEED_C = 4;

    typedef logic [(1<<TBL_IDX_W)-1:0][31:0] score_tbl_t;
    typedef logic [(1<<TBL_IDX_W)-1:0][31:0] speed_tbl_t;

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_v);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_v}) ? max_v : sum[31:0];
    endfunction

endpackage

// File: rtl/collision_pulse_gen.sv
// Holds SingleHitPulse for the collision frame, latches whether loot was hit and
// captures the loot type one clock after the hit.
module collision_pulse_gen
    import gold_miner_pkg::*;
#(
    parameter int LOOT_TYPES = 4,
    parameter int LOOT_W     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm_i,
    input  logic              is_loot_i,
    input  logic              release_i,
    input  logic              drop_i,
    input  logic [LOOT_W-1:0] loot_type_i,
    output logic              pulse_o,
    output logic [LOOT_W-1:0] captured_type_o
);

    logic              pulse_q,    pulse_d;
    logic              is_loot_q,  is_loot_d;
    logic              capture_q,  capture_d;
    logic [LOOT_W-1:0] captured_q, captured_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_q    <= 1'b0;
            is_loot_q  <= 1'b0;
            capture_q  <= 1'b0;
            captured_q <= '0;
        end else begin
            pulse_q    <= pulse_d;
            is_loot_q  <= is_loot_d;
            capture_q  <= capture_d;
            captured_q <= captured_d;
        end
    end

    always_comb begin
        pulse_d    = pulse_q;
        is_loot_d  = is_loot_q;
        capture_d  = arm_i;
        captured_d = captured_q;
        if (arm_i) begin
            pulse_d   = 1'b1;
            is_loot_d = is_loot_i;
        end else if (release_i) begin
            pulse_d = 1'b0;
        end
        // Out-of-range loot types and border hits both collapse to type 0.
        if (drop_i) begin
            captured_d = '0;
        end else if (capture_q) begin
            captured_d = (is_loot_q && (int'(loot_type_i) < LOOT_TYPES)) ? loot_type_i : '0;
        end
    end

    assign pulse_o         = pulse_q;
    assign captured_type_o = captured_q;

endmodule

// File: rtl/multi_level_fsm.sv
// Whole-game claw/loot controller: swing/dive/return cycle, scoring and level advance.
// Optional dynamite support is compiled in when DYNAMITE_EN is defined.
module multi_level_fsm
    import gold_miner_pkg::*;
#(
    parameter int         NUM_LEVELS = 4,
    parameter int         LOOT_TYPES = 4,
    parameter int         LOOT_W     = 2,
    parameter int         SCORE_W    = 12,
    parameter int         SPEED_W    = 4,
    parameter int         DEF_SPEED  = DEF_SPEED_C,
    parameter score_tbl_t LOOT_SCORE = {{12{32'd0}}, 32'd25, 32'd2, 32'd10, 32'd0},
    parameter speed_tbl_t LOOT_SPEED = {{12{32'd0}}, 32'd1, 32'd2, 32'd4, 32'd4},
    parameter int         GOAL_BASE  = 30,
    parameter int         GOAL_STEP  = 20,
    localparam int        LVL_W      = $clog2(NUM_LEVELS) + 1
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               start_game,
    input  logic               claw_dr,
    input  logic               borders_dr,
    input  logic               loot_dr,
    input  logic [LOOT_W-1:0]  loot_type,
    input  logic               timer_ended,
    input  logic               is_enter_pressed,
    input  logic               claw_returned,
`ifdef DYNAMITE_EN
    input  logic               use_dynamite,
    output logic [1:0]         dyn_count,
`endif
    output logic               claw_collision,
    output logic               loot_collision,
    output logic               SingleHitPulse,
    output logic [SPEED_W-1:0] move_speed,
    output logic [SCORE_W-1:0] level_score,
    output logic [SCORE_W-1:0] total_score,
    output logic [SCORE_W-1:0] goal,
    output logic [LVL_W-1:0]   level_idx,
    output logic               start_timer,
    output logic               level_ended,
    output logic               level_won,
    output logic               game_over
);

    localparam logic [31:0] SCORE_MAX = 32'((64'd1 << SCORE_W) - 64'd1);

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] level_score_q, level_score_d;
    logic [SCORE_W-1:0] total_score_q, total_score_d;
    logic [LVL_W-1:0]   level_idx_q, level_idx_d;
    logic               level_ended_q, level_ended_d;
    logic               level_won_q, level_won_d;

    logic               inter_loot_collision;
    logic               inter_claw_collision;
    logic               arm;
    logic               hold_release;
    logic               dyn_fire;
    logic               last_level;
    logic [LOOT_W-1:0]  captured_type;
    logic [LOOT_W-1:0]  score_type;
    logic [TBL_IDX_W-1:0] score_idx;
    logic [TBL_IDX_W-1:0] speed_idx;

    assign inter_loot_collision = claw_dr & loot_dr;
    assign inter_claw_collision = inter_loot_collision | (claw_dr & borders_dr);
    assign last_level           = (level_idx_q == LVL_W'(NUM_LEVELS - 1));
    assign arm                  = (state_q == ST_GOING_DOWN) && (state_d == ST_HOLD);
    assign hold_release         = (state_q == ST_HOLD) && (state_d != ST_HOLD);

`ifdef DYNAMITE_EN
    logic [1:0] dyn_count_q, dyn_count_d;

    assign dyn_fire = (state_q == ST_GOING_BACK) && !timer_ended && use_dynamite &&
                      (captured_type != '0) && (dyn_count_q != 2'd0);

    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) dyn_count_q <= 2'd0;
        else        dyn_count_q <= dyn_count_d;
    end

    always_comb begin
        dyn_count_d = dyn_count_q;
        if (state_q == ST_LEVEL_START) dyn_count_d = 2'd3;
        else if (dyn_fire)             dyn_count_d = dyn_count_q - 2'd1;
    end

    assign dyn_count = dyn_count_q;
`else
    assign dyn_fire = 1'b0;
`endif

    // A dynamite blast in the same clock as the return already forfeits the score.
    assign score_type = dyn_fire ? '0 : captured_type;
    assign score_idx  = TBL_IDX_W'(score_type);
    assign speed_idx  = TBL_IDX_W'(captured_type);

    collision_pulse_gen #(
        .LOOT_TYPES (LOOT_TYPES),
        .LOOT_W     (LOOT_W)
    ) u_pulse (
        .clk             (clk),
        .rst             (resetN),
        .arm_i           (arm),
        .is_loot_i       (inter_loot_collision),
        .release_i       (hold_release),
        .drop_i          (dyn_fire),
        .loot_type_i     (loot_type),
        .pulse_o         (SingleHitPulse),
        .captured_type_o (captured_type)
    );

    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            state_q       <= ST_IDLE;
            level_score_q <= '0;
            total_score_q <= '0;
            level_idx_q   <= '0;
            level_ended_q <= 1'b0;
            level_won_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            level_score_q <= level_score_d;
            total_score_q <= total_score_d;
            level_idx_q   <= level_idx_d;
            level_ended_q <= level_ended_d;
            level_won_q   <= level_won_d;
        end
    end

    // timer_ended is checked first in every playing state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:        if (start_game) state_d = ST_LEVEL_START;
            ST_LEVEL_START: state_d = ST_SWING;
            ST_SWING: begin
                if (timer_ended)           state_d = ST_LEVEL_END;
                else if (is_enter_pressed) state_d = ST_GOING_DOWN;
            end
            ST_GOING_DOWN: begin
                if (timer_ended)               state_d = ST_LEVEL_END;
                else if (inter_claw_collision) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (timer_ended)       state_d = ST_LEVEL_END;
                else if (startOfFrame) state_d = ST_GOING_BACK;
            end
            ST_GOING_BACK: begin
                if (timer_ended)        state_d = ST_LEVEL_END;
                else if (claw_returned) state_d = ST_SWING;
            end
            ST_LEVEL_END: begin
                if (is_enter_pressed)
                    state_d = (level_won_q && !last_level) ? ST_LEVEL_START : ST_GAME_DONE;
            end
            ST_GAME_DONE:   if (is_enter_pressed) state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        level_score_d = level_score_q;
        total_score_d = total_score_q;
        level_idx_d   = level_idx_q;
        level_ended_d = level_ended_q;
        level_won_d   = level_won_q;
        case (state_q)
            ST_IDLE: begin
                level_score_d = '0;
                total_score_d = '0;
                level_idx_d   = '0;
                level_ended_d = 1'b0;
                level_won_d   = 1'b0;
            end
            ST_LEVEL_START: begin
                level_score_d = '0;
                level_ended_d = 1'b0;
                level_won_d   = 1'b0;
            end
            ST_GOING_BACK: begin
                if (!timer_ended && claw_returned)
                    level_score_d = SCORE_W'(sat_add(32'(level_score_q),
                                                     LOOT_SCORE[score_idx], SCORE_MAX));
            end
            ST_LEVEL_END: begin
                if (is_enter_pressed && level_won_q) begin
                    total_score_d = SCORE_W'(sat_add(32'(total_score_q),
                                                     32'(level_score_q), SCORE_MAX));
                    if (!last_level) level_idx_d = level_idx_q + LVL_W'(1);
                end
            end
            default: ;
        endcase
        if ((state_q != ST_LEVEL_END) && (state_d == ST_LEVEL_END)) begin
            level_ended_d = 1'b1;
            level_won_d   = (level_score_q >= goal);
        end
    end

    always_comb begin
        move_speed = '0;
        case (state_q)
            ST_SWING, ST_GOING_DOWN, ST_HOLD: move_speed = SPEED_W'(DEF_SPEED);
            ST_GOING_BACK:                    move_speed = SPEED_W'(LOOT_SPEED[speed_idx]);
            default:                          move_speed = '0;
        endcase
    end

    assign goal = SCORE_W'(sat_add(32'(GOAL_BASE), 32'(level_idx_q) * 32'(GOAL_STEP), SCORE_MAX));

    assign claw_collision = inter_claw_collision & SingleHitPulse;
    assign loot_collision = inter_loot_collision & SingleHitPulse;
    assign level_score    = level_score_q;
    assign total_score    = total_score_q;
    assign level_idx      = level_idx_q;
    assign start_timer    = (state_q == ST_LEVEL_START);
    assign level_ended    = level_ended_q;
    assign level_won      = level_won_q;
    assign game_over      = (state_q == ST_GAME_DONE);

endmodule

// File: tb/tb_multi_level_fsm.sv
// Directed bench for multi_level_fsm; a second instance with SCORE_W=6 shares the stimulus
// to exercise score saturation.
module tb_multi_level_fsm;

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic        startOfFrame = 1'b0, start_game = 1'b0;
    logic        claw_dr = 1'b0, borders_dr = 1'b0, loot_dr = 1'b0;
    logic [1:0]  loot_type = 2'd0;
    logic        timer_ended = 1'b0, is_enter_pressed = 1'b0, claw_returned = 1'b0;

    logic        claw_collision, loot_collision, SingleHitPulse;
    logic [3:0]  move_speed;
    logic [11:0] level_score, total_score, goal;
    logic [2:0]  level_idx;
    logic        start_timer, level_ended, level_won, game_over;

    logic        s_claw_collision, s_loot_collision, s_pulse;
    logic [3:0]  s_move_speed;
    logic [5:0]  s_level_score, s_total_score, s_goal;
    logic [2:0]  s_level_idx;
    logic        s_start_timer, s_level_ended, s_level_won, s_game_over;

`ifdef DYNAMITE_EN
    logic        use_dynamite = 1'b0;
    logic [1:0]  dyn_count, s_dyn_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multi_level_fsm dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .start_game(start_game),
        .claw_dr(claw_dr), .borders_dr(borders_dr), .loot_dr(loot_dr), .loot_type(loot_type),
        .timer_ended(timer_ended), .is_enter_pressed(is_enter_pressed),
        .claw_returned(claw_returned),
`ifdef DYNAMITE_EN
        .use_dynamite(use_dynamite), .dyn_count(dyn_count),
`endif
        .claw_collision(claw_collision), .loot_collision(loot_collision),
        .SingleHitPulse(SingleHitPulse), .move_speed(move_speed),
        .level_score(level_score), .total_score(total_score), .goal(goal),
        .level_idx(level_idx), .start_timer(start_timer), .level_ended(level_ended),
        .level_won(level_won), .game_over(game_over)
    );

    multi_level_fsm #(.SCORE_W(6)) dut_small (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .start_game(start_game),
        .claw_dr(claw_dr), .borders_dr(borders_dr), .loot_dr(loot_dr), .loot_type(loot_type),
        .timer_ended(timer_ended), .is_enter_pressed(is_enter_pressed),
        .claw_returned(claw_returned),
`ifdef DYNAMITE_EN
        .use_dynamite(use_dynamite), .dyn_count(s_dyn_count),
`endif
        .claw_collision(s_claw_collision), .loot_collision(s_loot_collision),
        .SingleHitPulse(s_pulse), .move_speed(s_move_speed),
        .level_score(s_level_score), .total_score(s_total_score), .goal(s_goal),
        .level_idx(s_level_idx), .start_timer(s_start_timer), .level_ended(s_level_ended),
        .level_won(s_level_won), .game_over(s_game_over)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_enter();
        is_enter_pressed = 1'b1; tick(); is_enter_pressed = 1'b0;
    endtask

    // From SWING: fire, collide, and stay one clock in HOLD so the type is captured.
    task automatic dive(input logic [1:0] t, input logic with_loot, input logic with_border);
        press_enter();
        claw_dr = 1'b1; loot_dr = with_loot; borders_dr = with_border; loot_type = t;
        tick();
        chk("hit_pulse", SingleHitPulse, 1);
        chk("claw_coll", claw_collision, 1);
        chk("loot_coll", loot_collision, with_loot);
        tick();
        chk("coll_held", claw_collision, 1);
    endtask

    task automatic release_hold(input logic [3:0] exp_speed);
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
        chk("pulse_drop", SingleHitPulse, 0);
        chk("coll_gone", claw_collision, 0);
        claw_dr = 1'b0; loot_dr = 1'b0; borders_dr = 1'b0;
        chk("back_speed", move_speed, exp_speed);
    endtask

    task automatic come_back(input logic [11:0] exp_score);
        claw_returned = 1'b1; tick(); claw_returned = 1'b0;
        chk("score", level_score, exp_score);
        chk("swing_speed", move_speed, 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick(2);
        resetN = 1'b0;
        chk("rst_score", level_score, 0);
        chk("rst_total", total_score, 0);
        chk("rst_goal", goal, 30);
        chk("rst_speed", move_speed, 0);
        chk("rst_over", game_over, 0);
        chk("rst_timer", start_timer, 0);
        tick();
        chk("idle_hold", start_timer, 0);

        // Level 0
        start_game = 1'b1; tick(); start_game = 1'b0;
        chk("start_timer", start_timer, 1);
        tick();
        chk("start_timer_off", start_timer, 0);
        chk("swing_speed0", move_speed, 4);

        dive(2'd1, 1'b1, 1'b0);  release_hold(4'd4); come_back(12'd10);
        dive(2'd2, 1'b0, 1'b1);  release_hold(4'd4); come_back(12'd10);
        dive(2'd3, 1'b1, 1'b0);  release_hold(4'd1); come_back(12'd35);
        dive(2'd3, 1'b1, 1'b0);  release_hold(4'd1); come_back(12'd60);
        dive(2'd3, 1'b1, 1'b0);  release_hold(4'd1); come_back(12'd85);
        chk("sat_score", s_level_score, 63);

        timer_ended = 1'b1; tick(); timer_ended = 1'b0;
        chk("l0_ended", level_ended, 1);
        chk("l0_won", level_won, 1);
        chk("l0_speed", move_speed, 0);
        press_enter();
        chk("l0_total", total_score, 85);
        chk("l0_idx", level_idx, 1);
        chk("l1_goal", goal, 50);
        chk("l1_start_timer", start_timer, 1);
        chk("sat_total", s_total_score, 63);
        tick();
        chk("l1_score_clr", level_score, 0);
        chk("l1_ended_clr", level_ended, 0);

`ifdef DYNAMITE_EN
        chk("dyn_init", dyn_count, 3);
        dive(2'd3, 1'b1, 1'b0);  release_hold(4'd1);
        use_dynamite = 1'b1; tick(); use_dynamite = 1'b0;
        chk("dyn_speed", move_speed, 4);
        chk("dyn_count", dyn_count, 2);
        come_back(12'd0);
`endif

        // Level 1: one gold, then timer and return collide in the same clock
        dive(2'd1, 1'b1, 1'b0);  release_hold(4'd4); come_back(12'd10);
        dive(2'd1, 1'b1, 1'b0);  release_hold(4'd4);
        timer_ended = 1'b1; claw_returned = 1'b1; tick();
        timer_ended = 1'b0; claw_returned = 1'b0;
        chk("tie_score", level_score, 10);
        chk("tie_ended", level_ended, 1);
        chk("l1_lost", level_won, 0);
        chk("tie_speed", move_speed, 0);
        press_enter();
        chk("game_over", game_over, 1);
        chk("over_total", total_score, 85);
        press_enter();
        chk("idle_over", game_over, 0);
        tick();
        chk("idle_total", total_score, 0);
        chk("idle_idx", level_idx, 0);

        // Async reset while the claw comes back with heavy loot
        start_game = 1'b1; tick(); start_game = 1'b0; tick();
        dive(2'd1, 1'b1, 1'b0);  release_hold(4'd4); come_back(12'd10);
        dive(2'd3, 1'b1, 1'b0);  release_hold(4'd1);
        #2 resetN = 1'b1; #1;
        chk("arst_speed", move_speed, 0);
        chk("arst_score", level_score, 0);
        tick();
        resetN = 1'b0;
        start_game = 1'b1; tick(); start_game = 1'b0;
        chk("arst_restart", start_timer, 1);
        tick();

        // Async reset during HOLD drops the hit pulse at once
        dive(2'd2, 1'b1, 1'b0);
        #2 resetN = 1'b1; #1;
        chk("arst_pulse", SingleHitPulse, 0);
        chk("arst_coll", claw_collision, 0);
        tick();
        resetN = 1'b0;
        claw_dr = 1'b0; loot_dr = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_level_fsm.md
Name: multi_level_fsm

Overview:
- Parametrised successor to the single-level claw/loot controller.
- Runs a whole game of NUM_LEVELS levels: claw swing/dive/return cycle, one-shot collision pulse, per-loot score and return speed from parameter tables, per-level goal, level win/lose decision and advance.
- Sits between the claw/loot object logic and the game-screen/timer controller.

Parameters:
- NUM_LEVELS, 4, number of levels per game (1..16).
- LOOT_TYPES, 4, number of loot types. Type 0 is "none/border".
- LOOT_W, 2, width of loot_type; must satisfy 2^LOOT_W >= LOOT_TYPES.
- SCORE_W, 12, width of level and total score.
- SPEED_W, 4, width of move_speed.
- DEF_SPEED, 4, claw speed in swing, dive and empty return.
- LOOT_SCORE, {0,10,2,25}, per-type score, SCORE_W bits each, index 0 first.
- LOOT_SPEED, {4,4,2,1}, per-type return speed, SPEED_W bits each.
- GOAL_BASE, 30, goal for level 0.
- GOAL_STEP, 20, goal increment per level.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous, active-high reset (1 = reset)
- startOfFrame  in  1  one-clk pulse per frame
- start_game  in  1  level-sensitive start request
- claw_dr  in  1  claw drawing request
- borders_dr  in  1  border drawing request
- loot_dr  in  1  loot drawing request
- loot_type  in  LOOT_W  type of the loot currently drawn
- timer_ended  in  1  level timer expired
- is_enter_pressed  in  1  player fire/confirm
- claw_returned  in  1  claw back at origin
- claw_collision  out  1  inter_claw_collision AND SingleHitPulse
- loot_collision  out  1  inter_loot_collision AND SingleHitPulse
- SingleHitPulse  out  1  held high for the collision frame
- move_speed  out  SPEED_W  current claw/loot speed
- level_score  out  SCORE_W  score of current level
- total_score  out  SCORE_W  accumulated score across passed levels
- goal  out  SCORE_W  goal of current level (combinational from level_idx)
- level_idx  out  $clog2(NUM_LEVELS)+1  current level, 0-based
- start_timer  out  1  one-clk pulse on entry to SWING from a level start
- level_ended, level_won, game_over  out  1 each  status flags

Behaviour:
- Reset values: all outputs 0; state IDLE; level_idx 0; goal = GOAL_BASE.
- Collision terms:
  - inter_loot_collision = claw_dr & loot_dr.
  - inter_claw_collision = inter_loot_collision | (claw_dr & borders_dr).
- States and transitions:
  - IDLE: clear scores and level_idx. start_game -> LEVEL_START.
  - LEVEL_START: clear level_score, level_ended, level_won; pulse start_timer; -> SWING.
  - SWING: move_speed = DEF_SPEED. timer_ended -> LEVEL_END. Else is_enter_pressed -> GOING_DOWN.
  - GOING_DOWN: timer_ended -> LEVEL_END. Else inter_claw_collision -> HOLD; set SingleHitPulse; latch is_loot = inter_loot_collision.
  - HOLD: one clk after entry, latch captured_type = is_loot ? loot_type : 0.
    - timer_ended -> LEVEL_END.
    - Else startOfFrame -> clear SingleHitPulse, -> GOING_BACK.
  - GOING_BACK: move_speed = LOOT_SPEED[captured_type]. timer_ended -> LEVEL_END. Else claw_returned -> level_score += LOOT_SCORE[captured_type], -> SWING.
  - LEVEL_END: move_speed 0; level_ended 1; level_won = (level_score >= goal), registered on entry.
    - On is_enter_pressed, if won: total_score += level_score.
      - If last level -> GAME_DONE; else level_idx++ -> LEVEL_START.
    - On is_enter_pressed, if lost -> GAME_DONE.
  - GAME_DONE: game_over 1. is_enter_pressed -> IDLE.
- Priority: timer_ended beats every other event in the same clk.
- Latency: score is added the clk after claw_returned is sampled.
- Arithmetic: score adds saturate at 2^SCORE_W-1; no wrap. goal = GOAL_BASE + level_idx*GOAL_STEP, saturated.
- loot_type >= LOOT_TYPES is treated as type 0.
- Any illegal state -> IDLE.
- Reset mid-operation returns to IDLE within the same edge; SingleHitPulse drops immediately.

Optional Feature:
- DYNAMITE_EN defined:
  - Adds input use_dynamite and output dyn_count (2 bits, reset 0).
  - dyn_count becomes 3 at each LEVEL_START.
  - In GOING_BACK with captured_type != 0 and dyn_count > 0, use_dynamite sets captured_type to 0 (no score, DEF_SPEED return) and decrements dyn_count.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package gold_miner_pkg holds:
  - state enum type;
  - loot-table typedefs (packed score/speed arrays);
  - saturating-add function;
  - DEF_SPEED default constant.
- One sub-module: collision_pulse_gen. It owns SingleHitPulse, the is_loot latch and the captured_type capture, driven by arm/frame-release inputs from the FSM.

Test Plan:
- Reset: resetN=1 mid-GOING_BACK -> all outputs 0 and state IDLE the same edge; release, start_game -> start_timer pulse 1 clk.
- Gold grab: enter, claw_dr&loot_dr with loot_type=1 -> claw_collision 1 until next startOfFrame; move_speed 4; claw_returned -> level_score 10.
- Border hit: claw_dr&borders_dr only -> loot_collision 0, return at speed 4, level_score unchanged.
- Heavy loot: type 3 -> move_speed 1; two grabs -> level_score 50 >= goal 30; timer_ended, enter -> total_score 50, level_idx 1, goal 50.
- Lose and saturation: level 1 with score 20, timer_ended -> level_won 0, enter -> game_over. SCORE_W=6 with type 3 x3 -> score saturates at 63.
- Simultaneous events: timer_ended with claw_returned same clk -> LEVEL_END, no score added. With DYNAMITE_EN, use_dynamite on type 1 -> speed 4, score +0, dyn_count 2.
